if_queue: RTL and testbench
===========================

// Module: if_queue
// PURPOSE
//  Fetch queue between the pc/imemory fetch stage and instruction decode.
//  Captures each fetched (PC, instruction) pair and presents the pairs in order to decode.
//  Uses a valid/ready handshake on both sides.
//  A taken branch (Zero & Branch) flushes every queued entry so decode never sees wrong-path instructions.
//  It decouples fetch timing from decode stalls.
// PARAMETERS
//  DEPTH  4   number of entries; power of two, >=2
//  AW     32  PC width
//  DW     32  instruction width
// PORTS
//  clk          in   1            single clock; all state updates on posedge
//  rst_n        in   1            reset, asynchronous, active-low
//  fetch_valid  in   1            fetch presents a valid pair this cycle
//  fetch_pc     in   AW           PC of the fetched instruction
//  instruction  in   DW           imemory output for fetch_pc
//  fetch_ready  out  1            queue can accept: count < DEPTH
//  flush        in   1            taken branch (Zero & Branch); discard all entries
//  dec_valid    out  1            head entry valid
//  dec_pc       out  AW           head PC
//  dec_pc4      out  AW           head PC + 4, modulo 2^AW
//  dec_instr    out  DW           head instruction
//  dec_ready    in   1            decode consumes head this cycle
//  count        out  clog2(DEPTH)+1  occupancy, 0..DEPTH
//  overflow     out  1            sticky: set when fetch_valid=1 while fetch_ready=0
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - rd_ptr=wr_ptr=0, count=0, dec_valid=0, fetch_ready=1, overflow=0.
//   - dec_pc=0, dec_pc4=4, dec_instr=32'h0000_0000 (NOP).
//  Push = fetch_valid & fetch_ready & ~flush.
//   - Writes entry[wr_ptr] at posedge.
//   - wr_ptr wraps DEPTH-1 -> 0.
//  Pop = dec_valid & dec_ready & ~flush.
//   - Advances rd_ptr, which wraps DEPTH-1 -> 0.
//  Latency: a pair pushed at edge N is visible on dec_* after edge N. There is no combinational bypass.
//   - Empty queue with push and dec_ready high: dec_valid=1 from the next cycle.
//  Push and pop in the same cycle: count unchanged, both pointers advance.
//   - This is legal at any occupancy 1..DEPTH-1.
//   - When full, fetch_ready=0, so no push occurs; a pop still occurs.
//   - fetch_ready rises the cycle after that pop.
//  Pop while empty: impossible, because dec_valid=0.
//  dec_* when dec_valid=0: hold the last-driven values. Decode must ignore them.
//  dec_* are a function of the head entry only and are stable while dec_valid=1 and dec_ready=0.
//  flush=1 at an edge:
//   - count<=0, rd_ptr<=wr_ptr, dec_valid<=0.
//   - It overrides a simultaneous push and pop; the fetch pair in that cycle is dropped.
//   - The fetch side must re-present from the branch target on the following cycle.
//  overflow: set on any cycle with fetch_valid=1 and fetch_ready=0 and flush=0.
//   - It clears only on reset. Queue contents are unaffected.
//  rst_n asserted mid-operation: all entries are discarded immediately. dec_valid drops asynchronously.
//  Width: dec_pc4 = dec_pc + 32'd4 with the carry discarded. 32'hFFFF_FFFC -> 32'h0000_0000.
// STRUCTURE
//  Shared package (cpu_pkg):
//   - AW, DW.
//   - NOP_INSTR = 32'h0000_0000.
//   - PC_STEP = 4.
//  Sub-module if_queue_ram: DEPTH x (AW+DW) storage.
//   - Synchronous write, asynchronous read.
//   - No reset on the array.
//  The top level holds the pointers, count, overflow and handshake logic.
// TESTING
//  1. Reset: hold rst_n=0.
//     -> dec_valid=0, fetch_ready=1, count=0, dec_pc4=4, dec_instr=0.
//  2. Single push: PC=0x0000_0000, instr=0x8C01_0004 at one edge, dec_ready=0.
//     -> next cycle dec_valid=1, dec_pc=0, dec_pc4=4, count=1.
//  3. Fill: push PCs 0, 4, 8, 12 with dec_ready=0.
//     -> count=4, fetch_ready=0.
//     -> A 5th fetch_valid sets overflow=1 and dec_pc stays 0.
//     -> Then pop 4 times: PCs appear as 0, 4, 8, 12.
//  4. Streaming: fetch_valid=1 and dec_ready=1 for 10 cycles, PC stepping by 4, wr_ptr wrapping.
//     -> count stays 1 and there is no gap or reorder.
//  5. Flush: queue holds PCs 0x1100..0x110C. Assert flush together with a push of 0x1110.
//     -> next cycle count=0, dec_valid=0, 0x1110 dropped.
//     -> Then push 0x1111 and dec_pc=0x1111.
//  6. Async reset mid-stream with count=3.
//     -> dec_valid=0 before the next clk edge. Release leaves count=0 and overflow=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the fetch queue and its storage.
package cpu_pkg;
  localparam int          AW        = 32;
  localparam int          DW        = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_STEP   = 4;
endpackage

// File: rtl/if_queue_ram.sv
// Fetch queue storage: DEPTH x W entries, synchronous write, asynchronous read, no reset.
module if_queue_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];

  // Write the incoming entry at the write pointer
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/if_queue.sv
// Fetch queue between fetch and decode: in-order (PC, instruction) pairs,
// valid/ready on both sides, flushed on a taken branch.
module if_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = cpu_pkg::AW,
  parameter int DW    = cpu_pkg::DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_valid,
  input  logic [AW-1:0]          fetch_pc,
  input  logic [DW-1:0]          instruction,
  output logic                   fetch_ready,
  input  logic                   flush,
  output logic                   dec_valid,
  output logic [AW-1:0]          dec_pc,
  output logic [AW-1:0]          dec_pc4,
  output logic [DW-1:0]          dec_instr,
  input  logic                   dec_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  import cpu_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + DW;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_next;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  logic [EW-1:0] ram_rdata;
  logic [EW-1:0] head_entry;

  assign fetch_ready = (count < CW'(DEPTH));
  assign dec_pc4     = dec_pc + AW'(PC_STEP);

  // Handshakes, next read pointer, next occupancy and the entry that becomes head
  always_comb begin
    push       = fetch_valid & fetch_ready & ~flush;
    pop        = dec_valid & dec_ready & ~flush;
    rd_next    = pop ? rd_ptr + PW'(1) : rd_ptr;
    count_next = flush ? '0 : count + CW'(push) - CW'(pop);
    // The pair being written this cycle becomes head when nothing older remains
    head_entry = (push && (rd_next == wr_ptr)) ? {fetch_pc, instruction} : ram_rdata;
  end

  if_queue_ram #(
    .DEPTH(DEPTH),
    .W    (EW)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata({fetch_pc, instruction}),
    .raddr(rd_next),
    .rdata(ram_rdata)
  );

  // Pointer and occupancy bookkeeping; flush discards everything queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= flush ? wr_ptr : rd_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      count <= count_next;
    end
  end

  // Registered head presentation; holds last values while the queue is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid <= 1'b0;
      dec_pc    <= '0;
      dec_instr <= DW'(NOP_INSTR);
    end else begin
      dec_valid <= (count_next != '0);
      if (count_next != '0) {dec_pc, dec_instr} <= head_entry;
    end
  end

  // Sticky overflow: fetch offered a pair while the queue was full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (fetch_valid && !fetch_ready && !flush) overflow <= 1'b1;
  end
endmodule

// File: tb/tb_if_queue.sv
// Scoreboard bench for if_queue: stimulus pushes expected pairs, a monitor checks pops.
module tb_if_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] instruction;
  logic        fetch_ready;
  logic        flush;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc4;
  logic [31:0] dec_instr;
  logic        dec_ready;
  logic [2:0]  count;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  logic [63:0] exp_q[$];

  if_queue #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .instruction(instruction),
    .fetch_ready(fetch_ready), .flush(flush),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_pc4(dec_pc4), .dec_instr(dec_instr),
    .dec_ready(dec_ready), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs (called just after a posedge), record expectation, apply edge
  task automatic step(input bit fv, input logic [31:0] pc, input logic [31:0] ins,
                      input bit dr, input bit fl);
    fetch_valid = fv;
    fetch_pc    = pc;
    instruction = ins;
    dec_ready   = dr;
    flush       = fl;
    if (fl) exp_q.delete();
    else if (fv && fetch_ready) exp_q.push_back({pc, ins});
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Monitor: every accepted head is compared against the scoreboard front
  always @(negedge clk) begin
    if (rst_n && dec_valid && dec_ready && !flush) begin
      logic [63:0] e;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_empty_sb: got pc=%0h expected no entry", dec_pc);
      end else begin
        e = exp_q.pop_front();
        n_pops++;
        $display("pop pc=%08h instr=%08h", dec_pc, dec_instr);
        chk("pop_pc", {32'h0, dec_pc}, {32'h0, e[63:32]});
        chk("pop_pc4", {32'h0, dec_pc4}, {32'h0, e[63:32] + 32'd4});
        chk("pop_instr", {32'h0, dec_instr}, {32'h0, e[31:0]});
      end
    end
  end

  initial begin
    rst_n = 1'b0; fetch_valid = 0; fetch_pc = 0; instruction = 0; dec_ready = 0; flush = 0;
    // 1. reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_dec_pc4", 64'(dec_pc4), 64'd4);
    chk("rst_dec_instr", 64'(dec_instr), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2. single push, then consume
    step(1, 32'h0, 32'h8C01_0004, 0, 0);
    chk("single_valid", 64'(dec_valid), 64'd1);
    chk("single_pc", 64'(dec_pc), 64'd0);
    chk("single_pc4", 64'(dec_pc4), 64'd4);
    chk("single_instr", 64'(dec_instr), 64'h8C01_0004);
    chk("single_count", 64'(count), 64'd1);
    step(0, 0, 0, 1, 0);
    chk("single_drain_count", 64'(count), 64'd0);
    chk("single_drain_valid", 64'(dec_valid), 64'd0);

    // 3. fill, overflow, pop in order
    for (int i = 0; i < 4; i++) step(1, 32'(4 * i), ins_of(32'(4 * i)), 0, 0);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_ready", 64'(fetch_ready), 64'd0);
    step(1, 32'h10, ins_of(32'h10), 0, 0);
    chk("fill_overflow", 64'(overflow), 64'd1);
    chk("fill_head_pc", 64'(dec_pc), 64'd0);
    chk("fill_count_hold", 64'(count), 64'd4);
    step(1, 32'h20, ins_of(32'h20), 1, 0);
    chk("full_pop_count", 64'(count), 64'd3);
    chk("full_pop_ready", 64'(fetch_ready), 64'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    chk("fill_drain_count", 64'(count), 64'd0);

    // 4. streaming with pointer wrap
    step(1, 32'h100, ins_of(32'h100), 1, 0);
    for (int i = 1; i <= 10; i++) begin
      step(1, 32'h100 + 32'(4 * i), ins_of(32'h100 + 32'(4 * i)), 1, 0);
      chk("stream_count", 64'(count), 64'd1);
      chk("stream_valid", 64'(dec_valid), 64'd1);
    end
    step(0, 0, 0, 1, 0);
    chk("stream_end_count", 64'(count), 64'd0);

    // 5. flush overrides a simultaneous push
    for (int i = 0; i < 4; i++) step(1, 32'h1100 + 32'(4 * i), ins_of(32'h1100 + 32'(4 * i)), 0, 0);
    step(1, 32'h1110, ins_of(32'h1110), 0, 1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(dec_valid), 64'd0);
    step(1, 32'h1111, ins_of(32'h1111), 0, 0);
    chk("post_flush_pc", 64'(dec_pc), 64'h1111);
    chk("post_flush_count", 64'(count), 64'd1);
    step(0, 0, 0, 1, 0);

    // 6. asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(1, 32'h2000 + 32'(4 * i), ins_of(32'h2000 + 32'(4 * i)), 0, 0);
    chk("pre_reset_count", 64'(count), 64'd3);
    fetch_valid = 0; dec_ready = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(dec_valid), 64'd0);
    chk("async_reset_count", 64'(count), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("release_count", 64'(count), 64'd0);
    chk("release_overflow", 64'(overflow), 64'd0);
    chk("release_ready", 64'(fetch_ready), 64'd1);

    // PC+4 wraps modulo 2^32
    step(1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 0, 0);
    chk("wrap_pc4", 64'(dec_pc4), 64'd0);
    step(0, 0, 0, 1, 0);

    chk("total_pops", 64'(n_pops), 64'd18);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
